// File: rtl/gcd_unit_multi.sv
// gcd_unit_multi
//   Multi-mode GCD accelerator. It takes one {mode, tag, a, b} request over a
//   val/rdy receive interface. It iterates either Euclid subtract-and-swap
//   (mode=0) or binary Stein (mode=1). It returns {tag, result, cnt} over a
//   val/rdy send interface. cnt is the number of CALC cycles spent, and it
//   saturates at all-ones.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   recv_val  request valid
//   recv_rdy  request ready (independent of recv_val)
//   recv_msg  {mode, tag[p_tag_nbits], a[p_nbits], b[p_nbits]}
//   send_val  response valid
//   send_rdy  response ready
//   send_msg  {tag[p_tag_nbits], result[p_nbits], cnt[p_cnt_nbits]}
module gcd_unit_multi #(
  parameter int p_nbits     = 16,
  parameter int p_tag_nbits = 4,
  parameter int p_cnt_nbits = 8
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     recv_val,
  output logic                                     recv_rdy,
  input  logic [p_tag_nbits+2*p_nbits:0]           recv_msg,
  output logic                                     send_val,
  input  logic                                     send_rdy,
  output logic [p_tag_nbits+p_nbits+p_cnt_nbits-1:0] send_msg
);

  localparam int c_k_nbits = $clog2(p_nbits) + 1;
  localparam logic [c_k_nbits-1:0]   c_k_one   = 1;
  localparam logic [p_cnt_nbits-1:0] c_cnt_one = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   state_reg;
  logic [p_nbits-1:0]       a_reg;
  logic [p_nbits-1:0]       b_reg;
  logic [p_nbits-1:0]       result_reg;
  logic [c_k_nbits-1:0]     k_reg;
  logic [p_cnt_nbits-1:0]   cnt_reg;
  logic [p_tag_nbits-1:0]   tag_reg;
  logic                     mode_reg;

  // Request fields
  logic                     req_mode;
  logic [p_tag_nbits-1:0]   req_tag;
  logic [p_nbits-1:0]       req_a;
  logic [p_nbits-1:0]       req_b;

  assign req_mode = recv_msg[p_tag_nbits+2*p_nbits];
  assign req_tag  = recv_msg[2*p_nbits +: p_tag_nbits];
  assign req_a    = recv_msg[p_nbits +: p_nbits];
  assign req_b    = recv_msg[0 +: p_nbits];

  logic req_go;
  logic resp_go;

  // reset_n gates recv_rdy so that it drops the instant reset asserts,
  // even though the state register already reads IDLE.
  assign recv_rdy = reset_n &&
                    ((state_reg == ST_IDLE) || ((state_reg == ST_DONE) && send_rdy));
  assign send_val = (state_reg == ST_DONE);
  assign send_msg = {tag_reg, result_reg, cnt_reg};

  assign req_go  = recv_val && recv_rdy;
  assign resp_go = send_val && send_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      k_reg      <= '0;
      cnt_reg    <= '0;
      tag_reg    <= '0;
      mode_reg   <= 1'b0;
    end else if (req_go) begin
      // req_go can only fire in IDLE, or in DONE while the response is being
      // taken in the same cycle, so loading here covers both paths.
      a_reg     <= req_a;
      b_reg     <= req_b;
      tag_reg   <= req_tag;
      mode_reg  <= req_mode;
      k_reg     <= '0;
      cnt_reg   <= '0;
      state_reg <= ST_CALC;
    end else begin
      case (state_reg)
        ST_IDLE: ;

        ST_CALC: begin
          if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + c_cnt_one;
          end
          if (!mode_reg) begin
            // Euclid subtract-and-swap
            if (b_reg == '0) begin
              result_reg <= a_reg;
              state_reg  <= ST_DONE;
            end else if (a_reg < b_reg) begin
              a_reg <= b_reg;
              b_reg <= a_reg;
            end else begin
              a_reg <= a_reg - b_reg;
            end
          end else begin
            // Stein: k counts the common factors of two removed so far
            if (a_reg == '0) begin
              result_reg <= b_reg << k_reg;
              state_reg  <= ST_DONE;
            end else if (b_reg == '0) begin
              result_reg <= a_reg << k_reg;
              state_reg  <= ST_DONE;
            end else if (!a_reg[0] && !b_reg[0]) begin
              a_reg <= a_reg >> 1;
              b_reg <= b_reg >> 1;
              k_reg <= k_reg + c_k_one;
            end else if (!a_reg[0]) begin
              a_reg <= a_reg >> 1;
            end else if (!b_reg[0]) begin
              b_reg <= b_reg >> 1;
            end else if (a_reg >= b_reg) begin
              a_reg <= a_reg - b_reg;
            end else begin
              b_reg <= b_reg - a_reg;
            end
          end
        end

        ST_DONE: begin
          if (resp_go) begin
            state_reg <= ST_IDLE;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_unit_multi.sv
// tb_gcd_unit_multi
//   Directed vector bench for gcd_unit_multi. The bench uses a 16-bit
//   instance for most tests and a 32-bit instance for the wide-operand case.
module tb_gcd_unit_multi;

  logic        clk = 1'b0;
  logic        reset_n;

  // 16-bit instance
  logic        recv_val;
  logic        recv_rdy;
  logic [36:0] recv_msg;
  logic        send_val;
  logic        send_rdy;
  logic [27:0] send_msg;

  // 32-bit instance
  logic        recv_val32;
  logic        recv_rdy32;
  logic [68:0] recv_msg32;
  logic        send_val32;
  logic        send_rdy32;
  logic [43:0] send_msg32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gcd_unit_multi #(.p_nbits(16), .p_tag_nbits(4), .p_cnt_nbits(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .recv_val (recv_val),
    .recv_rdy (recv_rdy),
    .recv_msg (recv_msg),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg)
  );

  gcd_unit_multi #(.p_nbits(32), .p_tag_nbits(4), .p_cnt_nbits(8)) dut32 (
    .clk      (clk),
    .reset_n  (reset_n),
    .recv_val (recv_val32),
    .recv_rdy (recv_rdy32),
    .recv_msg (recv_msg32),
    .send_val (send_val32),
    .send_rdy (send_rdy32),
    .send_msg (send_msg32)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request to the 16-bit instance and collects its response.
  // lat counts clock edges from the accepting edge up to send_val.
  task automatic run16(input logic mode, input logic [3:0] tag,
                       input logic [15:0] a, input logic [15:0] b,
                       output logic [3:0] r_tag, output logic [15:0] r_res,
                       output logic [7:0] r_cnt, output int lat);
    int w;
    @(negedge clk);
    send_rdy = 1'b0;
    recv_msg = {mode, tag, a, b};
    recv_val = 1'b1;
    w = 0;
    while (!recv_rdy && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!recv_rdy) chk("accept_wait", 64'(recv_rdy), 64'd1);
    @(posedge clk);
    #1 recv_val = 1'b0;
    lat = 1;
    while (!send_val && lat < 70000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!send_val) chk("resp_wait", 64'(send_val), 64'd1);
    {r_tag, r_res, r_cnt} = send_msg;
    @(negedge clk);
    send_rdy = 1'b1;
    @(posedge clk);
    #1 send_rdy = 1'b0;
  endtask

  task automatic run32(input logic mode, input logic [3:0] tag,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [3:0] r_tag, output logic [31:0] r_res,
                       output logic [7:0] r_cnt, output int lat);
    @(negedge clk);
    send_rdy32 = 1'b0;
    recv_msg32 = {mode, tag, a, b};
    recv_val32 = 1'b1;
    chk("accept32", 64'(recv_rdy32), 64'd1);
    @(posedge clk);
    #1 recv_val32 = 1'b0;
    lat = 1;
    while (!send_val32 && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!send_val32) chk("resp_wait32", 64'(send_val32), 64'd1);
    {r_tag, r_res, r_cnt} = send_msg32;
    @(negedge clk);
    send_rdy32 = 1'b1;
    @(posedge clk);
    #1 send_rdy32 = 1'b0;
  endtask

  typedef struct {
    logic        mode;
    logic [3:0]  tag;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_res;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [3:0]  r_tag;
    logic [15:0] r_res;
    logic [7:0]  r_cnt;
    logic [31:0] r_res32;
    int          lat;
    int          w;
    logic        saw_resp;

    // mode, tag, a, b, expected result, expected CALC cycles
    vecs[0]  = '{1'b0, 4'd3,  16'd15, 16'd5,  16'd5, 8'd5};
    vecs[1]  = '{1'b1, 4'd7,  16'd12, 16'd8,  16'd4, 8'd7};
    vecs[2]  = '{1'b0, 4'd1,  16'd0,  16'd0,  16'd0, 8'd1};
    vecs[3]  = '{1'b1, 4'd2,  16'd0,  16'd0,  16'd0, 8'd1};
    vecs[4]  = '{1'b0, 4'd4,  16'd0,  16'd9,  16'd9, 8'd2};
    vecs[5]  = '{1'b1, 4'd5,  16'd0,  16'd9,  16'd9, 8'd1};
    vecs[6]  = '{1'b0, 4'd6,  16'd9,  16'd0,  16'd9, 8'd1};
    vecs[7]  = '{1'b1, 4'd8,  16'd9,  16'd0,  16'd9, 8'd1};
    vecs[8]  = '{1'b0, 4'd9,  16'd21, 16'd6,  16'd3, 8'd8};
    vecs[9]  = '{1'b0, 4'd10, 16'd7,  16'd7,  16'd7, 8'd3};
    vecs[10] = '{1'b1, 4'd11, 16'd21, 16'd6,  16'd3, 8'd7};
    vecs[11] = '{1'b1, 4'd12, 16'd48, 16'd18, 16'd6, 8'd8};

    reset_n    = 1'b0;
    recv_val   = 1'b0;
    recv_msg   = '0;
    send_rdy   = 1'b0;
    recv_val32 = 1'b0;
    recv_msg32 = '0;
    send_rdy32 = 1'b0;

    #1;
    chk("rst_send_val", 64'(send_val), 64'd0);
    chk("rst_recv_rdy", 64'(recv_rdy), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_recv_rdy", 64'(recv_rdy), 64'd1);
    chk("post_rst_send_val", 64'(send_val), 64'd0);
    chk("post_rst_send_msg", 64'(send_msg), 64'd0);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      run16(vecs[i].mode, vecs[i].tag, vecs[i].a, vecs[i].b, r_tag, r_res, r_cnt, lat);
      $display("txn vec%0d mode=%0d a=%0d b=%0d -> tag=%0d res=%0d cnt=%0d lat=%0d",
               i, vecs[i].mode, vecs[i].a, vecs[i].b, r_tag, r_res, r_cnt, lat);
      chk($sformatf("vec%0d_tag", i), 64'(r_tag), 64'(vecs[i].tag));
      chk($sformatf("vec%0d_res", i), 64'(r_res), 64'(vecs[i].exp_res));
      chk($sformatf("vec%0d_cnt", i), 64'(r_cnt), 64'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_cnt) + 64'd1);
    end

    // Wide operands on the 32-bit instance
    run32(1'b0, 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r_tag, r_res32, r_cnt, lat);
    $display("txn w32 euclid -> tag=%0d res=0x%0h cnt=%0d", r_tag, r_res32, r_cnt);
    chk("w32_euclid_res", 64'(r_res32), 64'hFFFF_FFFF);
    chk("w32_euclid_cnt", 64'(r_cnt), 64'd3);
    chk("w32_euclid_tag", 64'(r_tag), 64'd13);
    run32(1'b1, 4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r_tag, r_res32, r_cnt, lat);
    $display("txn w32 stein -> tag=%0d res=0x%0h cnt=%0d", r_tag, r_res32, r_cnt);
    chk("w32_stein_res", 64'(r_res32), 64'hFFFF_FFFF);
    chk("w32_stein_cnt", 64'(r_cnt), 64'd2);

    // Back-to-back: second request accepted as the first response is taken
    @(negedge clk);
    send_rdy = 1'b1;
    recv_msg = {1'b0, 4'd1, 16'd15, 16'd5};
    recv_val = 1'b1;
    chk("b2b_accept1", 64'(recv_rdy), 64'd1);
    @(posedge clk);
    #1 recv_msg = {1'b0, 4'd2, 16'd21, 16'd6};
    w = 0;
    while (!send_val && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("b2b_resp1_val", 64'(send_val), 64'd1);
    chk("b2b_resp1_msg", 64'(send_msg), 64'({4'd1, 16'd5, 8'd5}));
    chk("b2b_rdy_in_done", 64'(recv_rdy), 64'd1);
    $display("txn b2b resp1 msg=0x%0h", send_msg);
    @(posedge clk);
    #1 recv_val = 1'b0;
    chk("b2b_calc_sendval", 64'(send_val), 64'd0);
    chk("b2b_calc_recvrdy", 64'(recv_rdy), 64'd0);
    lat = 1;
    while (!send_val && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_resp2_msg", 64'(send_msg), 64'({4'd2, 16'd3, 8'd8}));
    chk("b2b_resp2_lat", 64'(lat), 64'd9);
    $display("txn b2b resp2 msg=0x%0h lat=%0d", send_msg, lat);
    @(posedge clk);
    #1 send_rdy = 1'b0;
    chk("b2b_retired", 64'(send_val), 64'd0);

    // Backpressure in DONE
    @(negedge clk);
    recv_msg = {1'b0, 4'd5, 16'd15, 16'd5};
    recv_val = 1'b1;
    @(posedge clk);
    #1 recv_val = 1'b0;
    w = 0;
    while (!send_val && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("bp_val", 64'(send_val), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_val%0d", i), 64'(send_val), 64'd1);
      chk($sformatf("bp_hold_msg%0d", i), 64'(send_msg), 64'({4'd5, 16'd5, 8'd5}));
      chk($sformatf("bp_hold_rdy%0d", i), 64'(recv_rdy), 64'd0);
    end
    $display("txn backpressure msg=0x%0h", send_msg);
    send_rdy = 1'b1;
    #1 chk("bp_rdy_follows", 64'(recv_rdy), 64'd1);
    @(posedge clk);
    #1 send_rdy = 1'b0;
    chk("bp_retired_val", 64'(send_val), 64'd0);
    chk("bp_idle_rdy", 64'(recv_rdy), 64'd1);

    // Asynchronous reset in the middle of a long Euclid run
    @(negedge clk);
    recv_msg = {1'b0, 4'd9, 16'hFFFF, 16'd1};
    recv_val = 1'b1;
    @(posedge clk);
    #1 recv_val = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_send_val", 64'(send_val), 64'd0);
    chk("midrst_recv_rdy", 64'(recv_rdy), 64'd0);
    chk("midrst_send_msg", 64'(send_msg), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("midrst_idle_rdy", 64'(recv_rdy), 64'd1);
    saw_resp = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1 if (send_val) saw_resp = 1'b1;
    end
    chk("midrst_no_resp", 64'(saw_resp), 64'd0);
    $display("txn reset mid-calc");

    run16(1'b0, 4'd9, 16'hFFFF, 16'd1, r_tag, r_res, r_cnt, lat);
    $display("txn sat euclid -> tag=%0d res=%0d cnt=%0d lat=%0d", r_tag, r_res, r_cnt, lat);
    chk("sat_res", 64'(r_res), 64'd1);
    chk("sat_cnt", 64'(r_cnt), 64'd255);
    chk("sat_tag", 64'(r_tag), 64'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
